// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: DEPTH-entry FIFO of {inst, pc} pairs with flush and global stall.
// Latency: one cycle from push to out_valid; no same-cycle bypass; 1/cycle streaming throughput.
// Backpressure: in_ready drops when full, stalled (rdy=0) or flushing; head holds until out_ready.
module if_id_queue #(
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_valid,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              in_ready,
  output logic              out_valid,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  input  logic              out_ready,
  input  logic              flush,
  output logic [PTR_W:0]    count
);

  // Occupancy value meaning "every slot holds an entry".
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;

  logic not_empty;
  logic not_full;
  logic push;
  logic pop;
  entry_t head;

  assign not_empty = (cnt_q != '0);
  assign not_full  = (cnt_q != FULL_CNT);

  // A full queue refuses pushes even when the head is popped this cycle,
  // which keeps in_ready independent of out_ready (no comb path ID->IF).
  assign in_ready  = rdy && !flush && not_full;
  assign out_valid = rdy && not_empty;

  // in_ready and out_valid are already rdy-gated, so a stall blocks both.
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready && !flush;

  // Head data is forced to zero when empty so ID never sees stale entries.
  assign head     = mem_q[rd_ptr_q];
  assign out_inst = not_empty ? head.inst : '0;
  assign out_pc   = not_empty ? head.pc   : '0;
  assign count    = cnt_q;

  // Next-state for pointers and occupancy: stall, then flush, then push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (!rdy) begin
      // Frozen: everything holds.
    end else if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        cnt_d = cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Control state register; reset clears occupancy without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write; contents are don't-care after reset since cnt gates visibility.
  // push already excludes stall and flush cycles.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{inst: in_inst, pc: in_pc};
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, fill, drain, streaming wrap, flush, stall, async reset.
// Inputs change 2 time units after the rising edge; outputs are sampled mid-cycle.
module tb_if_id_queue;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;

  logic              clk;
  logic              rst;
  logic              rdy;
  logic              in_valid;
  logic [INST_W-1:0] in_inst;
  logic [PC_W-1:0]   in_pc;
  logic              in_ready;
  logic              out_valid;
  logic [INST_W-1:0] out_inst;
  logic [PC_W-1:0]   out_pc;
  logic              out_ready;
  logic              flush;
  logic [PTR_W:0]    count;

  int tests_run;
  int tests_failed;

  logic [31:0] fill_inst [4];

  if_id_queue #(
    .INST_W(INST_W),
    .PC_W  (PC_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .in_valid (in_valid),
    .in_inst  (in_inst),
    .in_pc    (in_pc),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_inst (out_inst),
    .out_pc   (out_pc),
    .out_ready(out_ready),
    .flush    (flush),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    fill_inst[0] = 32'h0000_0013;
    fill_inst[1] = 32'h0010_0093;
    fill_inst[2] = 32'h0020_0113;
    fill_inst[3] = 32'h0030_0193;

    rst = 1'b0; rdy = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
    out_ready = 1'b0; flush = 1'b0;

    // Reset state
    #3;
    chk("rst_count",     count,     0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_out_inst",  out_inst,  0);
    chk("rst_out_pc",    out_pc,    0);

    // Release reset, fill with out_ready=0
    #9;
    rst = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_inst = fill_inst[i]; in_pc = 32'(4 * i);
      #1;
      chk($sformatf("fill_in_ready_%0d", i), in_ready, 1);
      tick();
      chk($sformatf("fill_count_%0d", i), count, 64'(i + 1));
      chk($sformatf("fill_out_valid_%0d", i), out_valid, 1);
      chk($sformatf("fill_head_inst_%0d", i), out_inst, 32'h0000_0013);
      chk($sformatf("fill_head_pc_%0d", i), out_pc, 0);
    end
    // Full: a further push attempt is refused and changes nothing
    in_inst = 32'hFFFF_FFFF; in_pc = 32'h0000_0FF0;
    #1;
    chk("full_in_ready", in_ready, 0);
    tick();
    chk("full_count_hold", count, 4);
    in_valid = 1'b0;

    // Drain in order
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("drain_valid_%0d", i), out_valid, 1);
      chk($sformatf("drain_inst_%0d", i), out_inst, fill_inst[i]);
      chk($sformatf("drain_pc_%0d", i), out_pc, 64'(4 * i));
      tick();
    end
    chk("drain_empty_valid", out_valid, 0);
    chk("drain_empty_inst",  out_inst,  0);
    chk("drain_empty_pc",    out_pc,    0);
    chk("drain_empty_count", count,     0);

    // Streaming push+pop every cycle across pointer wrap
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_inst = 32'h0000_1000 + 32'(i); in_pc = 32'h100 + 32'(4 * i);
      tick();
      chk($sformatf("stream_count_%0d", i), count, 1);
      chk($sformatf("stream_pc_%0d", i), out_pc, 64'(32'h100 + 32'(4 * i)));
      chk($sformatf("stream_inst_%0d", i), out_inst, 64'(32'h1000 + 32'(i)));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_count", count, 0);

    // Flush with concurrent push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_inst = 32'h0000_2000 + 32'(i); in_pc = 32'h200 + 32'(4 * i);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_flush_count", count, 3);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'hDEAD_BEEF; in_pc = 32'h0000_0400;
    out_ready = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_count",     count,     0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_inst",  out_inst,  0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h0BAD_C0DE; in_pc = 32'h0000_0300;
    tick();
    in_valid = 1'b0;
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_inst",  out_inst,  32'h0BAD_C0DE);
    chk("post_flush_pc",    out_pc,    32'h0000_0300);
    chk("post_flush_count", count,     1);

    // rdy stall with 2 entries
    in_valid = 1'b1; in_inst = 32'h0000_3004; in_pc = 32'h0000_0304;
    tick();
    chk("pre_stall_count", count, 2);
    rdy = 1'b0; in_inst = 32'h0000_3333; in_pc = 32'h0000_0333; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_in_ready_%0d", i), in_ready, 0);
      chk($sformatf("stall_out_valid_%0d", i), out_valid, 0);
      chk($sformatf("stall_count_%0d", i), count, 2);
      tick();
    end
    chk("stall_count_after", count, 2);
    rdy = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("unstall_valid", out_valid, 1);
    chk("unstall_pc",    out_pc,    32'h0000_0300);
    chk("unstall_inst",  out_inst,  32'h0BAD_C0DE);

    // Async reset between edges with 3 entries
    in_valid = 1'b1; in_inst = 32'h0000_3008; in_pc = 32'h0000_0308;
    tick();
    in_valid = 1'b0;
    chk("pre_arst_count", count, 3);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_count",     count,     0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_inst",  out_inst,  0);
    #10;
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised IF→ID decoupling buffer; successor to the single-entry IF/ID latch.
- Holds up to DEPTH fetched {inst, pc} pairs in FIFO order.
- Explicit valid/ready handshakes on both sides replace the inst==0 / done-pulse protocol.
- Adds a synchronous flush for branch/jump redirect.
- Honours the global rdy stall.

Parameters:
INST_W, 32, instruction width in bits
PC_W, 32, PC width in bits
DEPTH, 4, entry count; power of two, >= 2
PTR_W, 2, log2(DEPTH); must match DEPTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
rdy  in  1  global ready; 0 freezes the block
in_valid  in  1  IF presents an instruction
in_inst  in  INST_W  fetched instruction
in_pc  in  PC_W  PC of in_inst
in_ready  out  1  queue accepts a push this cycle
out_valid  out  1  head entry is valid for ID
out_inst  out  INST_W  head instruction
out_pc  out  PC_W  head PC
out_ready  in  1  ID consumes the head this cycle
flush  in  1  discard all entries (redirect)
count  out  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- State: storage mem[DEPTH], wr_ptr and rd_ptr (PTR_W bits, natural wrap DEPTH-1→0), cnt (PTR_W+1 bits).
- Reset (rst=0, async): wr_ptr=rd_ptr=cnt=0, so out_valid=0, in_ready=0 (rdy-gated, see below), count=0, out_inst=0, out_pc=0. Storage contents are don't-care.
- Combinational outputs:
  - in_ready = rdy && !flush && (cnt != DEPTH)
  - out_valid = rdy && (cnt != 0)
  - out_inst/out_pc = mem[rd_ptr] when cnt != 0, else 0
  - count = cnt
- push = in_valid && in_ready; pop = out_valid && out_ready && !flush.
- Clock edge, priority order:
  1. rdy=0: hold all state; no push or pop.
  2. flush=1: wr_ptr=rd_ptr=cnt=0. Same-cycle push and pop are discarded.
  3. Otherwise:
     - push: mem[wr_ptr] ← {in_inst, in_pc}; wr_ptr+1.
     - pop: rd_ptr+1.
     - cnt += push − pop; push and pop together leave cnt unchanged.
- Latency:
  - Entry pushed into an empty queue appears at out_valid on the next cycle. There is no same-cycle bypass.
  - Throughput is 1/cycle with concurrent push and pop.
- Full (cnt=DEPTH): in_ready=0 even if a pop occurs the same cycle. Full-cycle pop-then-push is not supported; IF retries next cycle.
- Empty (cnt=0): out_valid=0, out_ready ignored, outputs read 0.
- Stability: out_inst/out_pc hold while out_valid && !out_ready and no flush.
- in_valid with in_ready=0: no state change. IF must hold its data.
- Order is strict FIFO, including across pointer wrap.
- Reset mid-operation clears occupancy immediately, independent of clk.

Test Plan:
- Reset and fill: release rst; push 0x00000013@pc 0x0, 0x00100093@0x4, 0x00200113@0x8, 0x00300193@0xC with out_ready=0. Required: count 1,2,3,4; in_ready=0 after the 4th push; out_inst=0x00000013, out_pc=0x0 held throughout.
- Drain and order: from full, out_ready=1 for 4 cycles. Required: outputs 0x13/0x0, 0x00100093/0x4, 0x00200113/0x8, 0x00300193/0xC, then out_valid=0, out_inst=0, count=0.
- Streaming and wrap: push and pop every cycle for 10 instructions, pc 0x100 step 4. Required: count stays 1 after the first push; out_pc sequence 0x100..0x124 in order across pointer wrap.
- Flush: 3 entries queued; assert flush with in_valid=1 (inst 0xDEADBEEF) and out_ready=1. Required: next cycle count=0 and out_valid=0; 0xDEADBEEF never appears at the output; a subsequent push appears normally.
- rdy stall: 2 entries queued; hold rdy=0 for 3 cycles with in_valid=1 and out_ready=1. Required: in_ready=0 and out_valid=0; count stays 2; after rdy=1 the same head entry is presented.
- Async reset mid-stream: drive rst=0 between clock edges with count=3. Required: count=0 and out_valid=0 immediately, before the next edge.
